// File: rtl/debouncer_pkg.sv
// Shared defaults and sizing helper for the multi-channel debouncer.
package debouncer_pkg;

    localparam int DEF_STABLE_CYCLES = 16;
    localparam int DEF_SYNC_STAGES   = 2;

    // Counter width for a window of n cycles; never narrower than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced channel: synchroniser chain, stability counter, level and edge pulses.
module debounce_channel
    import debouncer_pkg::*;
#(
    parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int   SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter logic INIT_LEVEL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic signal_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic flip_o
);

    localparam int             CW      = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 2) begin : g_chk_stable
        $error("debounce_channel: STABLE_CYCLES must be >= 2");
    end
    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("debounce_channel: SYNC_STAGES must be >= 2");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    // Any cycle of agreement restarts the count; the output flips only on the last disagreeing cycle.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d   = '0;
            level_d = s;
            rise_d  = s;
            fall_d  = ~s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= {SYNC_STAGES{INIT_LEVEL}};
            cnt_q   <= '0;
            level_q <= INIT_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], signal_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign flip_o  = rise_d | fall_d;

endmodule

// File: rtl/debouncer_multi.sv
// Multi-channel debouncer: independent channels plus a shared registered any-edge flag.
module debouncer_multi
    import debouncer_pkg::*;
#(
    parameter int   CHANNELS      = 4,
    parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int   SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter logic INIT_LEVEL    = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] signal_in,
    output logic [CHANNELS-1:0] signal_out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                any_edge
);

    if (CHANNELS < 1) begin : g_chk_channels
        $error("debouncer_multi: CHANNELS must be >= 1");
    end

    logic [CHANNELS-1:0] flip;
    logic                any_edge_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .SYNC_STAGES   (SYNC_STAGES),
            .INIT_LEVEL    (INIT_LEVEL)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .signal_i (signal_in[i]),
            .level_o  (signal_out[i]),
            .rise_o   (rise[i]),
            .fall_o   (fall[i]),
            .flip_o   (flip[i])
        );
    end

    // Registered from the channels' next-state pulses so it lines up with rise/fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            any_edge_q <= 1'b0;
        end else begin
            any_edge_q <= |flip;
        end
    end

    assign any_edge = any_edge_q;

endmodule

// File: tb/tb_debouncer_multi.sv
// Randomised and scenario-driven bench for debouncer_multi against a window-based reference model.
module tb_debouncer_multi;

    localparam int   CH   = 4;
    localparam int   SC   = 4;
    localparam int   SS   = 2;
    localparam logic INIT = 1'b0;
    localparam int   LAT  = SS + SC;
    localparam int   MAXE = 2000;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] signal_in;
    logic [CH-1:0] signal_out;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic          any_edge;

    always #10 clk = ~clk;

    debouncer_multi #(
        .CHANNELS      (CH),
        .STABLE_CYCLES (SC),
        .SYNC_STAGES   (SS),
        .INIT_LEVEL    (INIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .signal_in  (signal_in),
        .signal_out (signal_out),
        .rise       (rise),
        .fall       (fall),
        .any_edge   (any_edge)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int t     = 0;

    logic [CH-1:0] in_h  [MAXE];
    logic          rst_h [MAXE];
    logic [CH-1:0] m_out, m_rise, m_fall;
    logic          m_any;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, t);
        end
    endtask

    // Value the filter sees at edge j: the input SS edges earlier, unless a reset flushed the chain.
    function automatic logic seen(input int ch, input int j);
        if (j <= SS) return INIT;
        for (int k = 1; k <= SS; k++) begin
            if (rst_h[j-k]) return INIT;
        end
        return in_h[j-SS][ch];
    endfunction

    // Output flips at edge t exactly when the last SC seen values all disagree with it.
    task automatic model_step();
        bit ok;
        m_rise = '0;
        m_fall = '0;
        for (int ch = 0; ch < CH; ch++) begin
            if (rst_h[t]) begin
                m_out[ch] = INIT;
            end else if (t > SC) begin
                ok = 1'b1;
                for (int j = t - SC + 1; j <= t; j++) begin
                    if (seen(ch, j) == m_out[ch]) ok = 1'b0;
                end
                if (ok) begin
                    m_out[ch]  = ~m_out[ch];
                    m_rise[ch] = m_out[ch];
                    m_fall[ch] = ~m_out[ch];
                end
            end
        end
        m_any = |(m_rise | m_fall);
    endtask

    task automatic tick(input logic r, input logic [CH-1:0] v);
        rst       = r;
        signal_in = v;
        @(posedge clk);
        t++;
        if (t >= MAXE) begin
            $display("FAIL edge_budget: got %0d expected < %0d", t, MAXE);
            $fatal(1, "edge budget exceeded");
        end
        in_h[t]  = v;
        rst_h[t] = r;
        model_step();
        #1;
        chk("signal_out", signal_out, m_out);
        chk("rise", rise, m_rise);
        chk("fall", fall, m_fall);
        chk("any_edge", any_edge, m_any);
        @(negedge clk);
    endtask

    task automatic hold(input logic [CH-1:0] v, input int n);
        for (int i = 0; i < n; i++) tick(1'b0, v);
    endtask

    // Hold v and report after how many edges the wanted pulse first appears on channel ch.
    task automatic wait_pulse(input string tag, input logic [CH-1:0] v, input int ch,
                              input bit want_rise);
        int lat;
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            tick(1'b0, v);
            if (lat < 0 && (want_rise ? rise[ch] : fall[ch])) lat = i;
        end
        chk(tag, lat, LAT);
    endtask

    initial begin
        int lat, nany, nrise1;
        logic f2;
        logic [CH-1:0] cur;
        logic [CH-1:0] bounce [9];

        rst       = 1'b1;
        signal_in = '0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 4'hF);
            chk("rst_signal_out", signal_out, 0);
            chk("rst_pulses", {rise, fall, any_edge}, 0);
        end

        lat  = -1;
        nany = 0;
        for (int i = 1; i <= 12; i++) begin
            tick(1'b0, 4'hF);
            if (lat < 0 && rise == 4'hF) lat = i;
            if (any_edge) nany++;
        end
        chk("release_rise_lat", lat, LAT);
        chk("release_any_cycles", nany, 1);
        chk("release_level", signal_out, 4'hF);

        hold(4'h0, 10);
        wait_pulse("step_rise0_lat", 4'b0001, 0, 1'b1);

        bounce = '{4'b0011, 4'b0001, 4'b0011, 4'b0011, 4'b0001,
                   4'b0011, 4'b0011, 4'b0011, 4'b0001};
        nrise1 = 0;
        for (int i = 0; i < 9; i++) begin
            tick(1'b0, bounce[i]);
            if (rise[1] || fall[1]) nrise1++;
        end
        chk("bounce_no_pulse", nrise1, 0);
        chk("bounce_level1", signal_out[1], 0);
        wait_pulse("bounce_run_lat", 4'b0011, 1, 1'b1);

        hold(4'b0111, 10);
        wait_pulse("fall2_lat", 4'b0011, 2, 1'b0);

        tick(1'b0, 4'b1011);
        tick(1'b0, 4'b1011);
        tick(1'b1, 4'b1011);
        chk("midreset_level3", signal_out[3], 0);
        wait_pulse("midreset_rise3_lat", 4'b1011, 3, 1'b1);

        hold(4'b0100, 10);
        lat  = -1;
        nany = 0;
        f2   = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick(1'b0, 4'b0001);
            if (lat < 0 && rise[0]) begin
                lat = i;
                f2  = fall[2];
            end
            if (any_edge) nany++;
        end
        chk("indep_rise0_lat", lat, LAT);
        chk("indep_fall2_coincide", f2, 1);
        chk("indep_any_cycles", nany, 1);

        cur = signal_in;
        for (int i = 0; i < 800; i++) begin
            for (int b = 0; b < CH; b++) begin
                if ($urandom_range(0, 4) == 0) cur[b] = ~cur[b];
            end
            tick(($urandom_range(0, 199) == 0), cur);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/debouncer_multi.md
# debouncer_multi

Parametrised multi-channel debouncer: each of CHANNELS asynchronous inputs (buttons, switches, open-drain flags) is synchronised, filtered by a consecutive-stable-cycles counter, and delivered as a clean level plus one-cycle rise/fall pulses. It supersedes the single-channel, fixed-window debouncer. It sits at the board-input boundary, ahead of any control logic that consumes switch state or edges.

## Interface
- CHANNELS, 4, number of independent input channels (>= 1)
- STABLE_CYCLES, 16, consecutive post-sync cycles of disagreement required before the output flips (>= 2)
- SYNC_STAGES, 2, synchroniser flop depth per channel (>= 2)
- INIT_LEVEL, 1'b0, reset value of the synchroniser flops and of signal_out, applied to every channel
- clk  input  1  single system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- signal_in  input  CHANNELS  raw asynchronous inputs
- signal_out  output  CHANNELS  debounced levels
- rise  output  CHANNELS  one-cycle pulse when signal_out goes 0->1
- fall  output  CHANNELS  one-cycle pulse when signal_out goes 1->0
- any_edge  output  1  registered OR-reduction of rise|fall, coincident with those pulses

## Operation
- Channels are fully independent. There is no cross-channel interaction except any_edge.
- Per channel:
  - SYNC_STAGES-deep flop chain; its last stage is s.
  - Counter cnt, width $clog2(STABLE_CYCLES).
  - Output register q drives signal_out.
- Each edge, when rst=0:
  - s == q: cnt <= 0; rise and fall go 0.
  - s != q and cnt < STABLE_CYCLES-1: cnt <= cnt+1; pulses go 0.
  - s != q and cnt == STABLE_CYCLES-1: q <= s; cnt <= 0. rise <= s, fall <= ~s, each for exactly one cycle.
- A glitch shorter than STABLE_CYCLES post-sync cycles never reaches signal_out. Any single cycle of agreement restarts the count from 0.
- Counter never exceeds STABLE_CYCLES-1. There is no wrap.
- Reset values: sync flops = INIT_LEVEL, signal_out = INIT_LEVEL, cnt = 0, rise = fall = any_edge = 0. The reset value of signal_out never generates a pulse.
- Reset asserted mid-count discards the count. After rst falls, filtering restarts from the reset state.
- rise and fall are never asserted together on one channel.

## Timing
- All outputs are registered. There are no combinational paths from signal_in.
- Latency: signal_in changes and stays stable before edge E0. signal_out and the matching pulse update at edge E(SYNC_STAGES+STABLE_CYCLES-1), i.e. SYNC_STAGES+STABLE_CYCLES edges including E0.
- Pulses:
  - rise and fall are high for exactly the cycle following the flip edge, aligned with the new signal_out value.
  - any_edge is aligned with them.
- Minimum spacing between two output transitions on one channel is STABLE_CYCLES cycles.
- Simultaneous flips on several channels produce simultaneous pulses and a single any_edge cycle.

## Structure
- Sub-module debounce_channel: one channel, containing the sync chain, the counter and q/rise/fall. It is instantiated CHANNELS times in a generate loop. The top holds only the generate loop and the any_edge register.
- Shared package debouncer_pkg holds:
  - default constants DEF_STABLE_CYCLES = 16 and DEF_SYNC_STAGES = 2;
  - function cnt_width(n) returning max(1,$clog2(n)), used by debounce_channel.
- Elaboration-time checks: STABLE_CYCLES >= 2, SYNC_STAGES >= 2, CHANNELS >= 1.

## Test plan
Bench configuration: CHANNELS=4, STABLE_CYCLES=4, SYNC_STAGES=2, INIT_LEVEL=0, 20 ns clock.
- Reset: hold rst=1 for 3 cycles with signal_in=4'hF.
  - During reset: signal_out=0, rise=fall=0, any_edge=0.
  - After release: ch0-3 rise together at edge 6 after release; any_edge high for one cycle.
- Clean step: ch0 0->1 before edge E0 -> signal_out[0]=1 and rise[0]=1 after E5; rise[0]=0 one cycle later; ch1-3 unchanged.
- Bounce rejection: ch1 toggles with high pulses of 1, 2 and 3 cycles separated by 1 low cycle -> signal_out[1] stays 0 and no pulse. A following 4+ cycle stable-high run flips it exactly 6 edges after the run starts.
- Fall edge: ch2 at 1, drops to 0 and stays -> fall[2] one-cycle pulse, rise[2] stays 0, signal_out[2]=0 at the same edge.
- Reset mid-count: ch3 mismatching for 2 cycles, then rst=1 for 1 cycle -> no pulse; cnt restarts, and the flip occurs a full 6 edges after rst falls.
- Independence: ch0 rises while ch2 falls in the same cycle -> rise[0] and fall[2] coincide; any_edge is high for one cycle only.
